core_alu_arbiter: RTL and testbench
===================================

// Module: core_alu_arbiter
//
// PURPOSE
// - Shares one core_alu instance between N requesters, e.g. the issue stage and an address-generation unit.
// - Round-robin arbitration, valid/ready request handshake, registered result with a 1-cycle minimum latency.
// - Sits between the requesters and the single ALU. The ALU itself stays purely combinational.
//
// PARAMETERS
// - W     16  datapath width, passed to core_alu
// - N     2   number of requesters, N >= 1
// - CNTW  16  width of each grant counter (only used with CORE_ALU_ARB_PERF_EN)
//
// PORTS
// - clk        in   1      clock, all state updates on rising edge
// - rst_n      in   1      synchronous reset, active-low
// - req_valid  in   N      requester i presents an operation
// - req_ready  out  N      one-hot or zero; requester i's operation is accepted this cycle
// - req_op     in   N x alu_op  operation per requester
// - req_a      in   N x W  operand a per requester
// - req_b      in   N x W  operand b per requester
// - rsp_valid  out  N      one-hot or zero; rsp_q holds the result for requester i
// - rsp_ready  in   N      requester i consumes its response
// - rsp_q      out  W      registered ALU result, shared by all requesters
// - grant_cnt  out  N x CNTW  accepted-request count per requester (only with CORE_ALU_ARB_PERF_EN)
//
// BEHAVIOUR
// - FSM states:
//   - IDLE: no result held.
//   - HOLD: result held for owner index `own`.
// - slot_free = (state==IDLE) | (state==HOLD & rsp_ready[own]).
// - Arbitration:
//   - Winner w is the first i with req_valid[i], scanning from ptr upward modulo N.
//   - req_ready[w] = slot_free. All other req_ready bits are 0.
//   - req_ready is combinational from req_valid/rsp_ready. Requesters must not make req_valid depend on req_ready.
// - Accept, i.e. req_valid[w] & req_ready[w], at edge t:
//   - The ALU computes with req_op[w], req_a[w], req_b[w] in the same cycle.
//   - rsp_q <= q. own <= w. state <= HOLD.
//   - ptr <= (w+1) mod N.
//   - rsp_valid[w] = 1 from cycle t+1.
// - In HOLD, rsp_valid[own] = 1. rsp_q and own stay stable until rsp_ready[own] is seen.
// - rsp_ready[own] with no accept in the same cycle: state <= IDLE.
// - rsp_ready[own] with an accept in the same cycle: back-to-back, state stays HOLD with the new result. Throughput is 1 op/cycle.
// - Requests with valid held while not ready must keep op/a/b stable. The arbiter does not latch operands before accept.
// - rsp_ready[i] for i != own, or any rsp_ready in IDLE, is ignored.
// - ALU arithmetic is unchanged by the arbiter:
//   - ADD/SUB wrap modulo 2^W.
//   - SHL/SHR by b >= W yield 0.
// - N=1: ptr is constant 0, and the block degenerates to a 1-entry output register with handshake.
// - Reset (rst_n=0 at an edge):
//   - state=IDLE, ptr=0, own=0, rsp_q=0, rsp_valid=0.
//   - req_ready=0 during the reset cycle.
//   - Any held result is discarded, even mid-transfer. No response is issued for it.
//
// CONFIGURATION
// - CORE_ALU_ARB_PERF_EN defined:
//   - Adds the grant_cnt port.
//   - grant_cnt[i] increments on each accept of requester i and saturates at 2^CNTW-1.
//   - Cleared to 0 by reset.
// - CORE_ALU_ARB_PERF_EN undefined: no counters and no grant_cnt port. Behaviour is otherwise identical.
//
// TESTING
// - Reset: hold rst_n=0 with req_valid=all ones -> req_ready=0 and rsp_valid=0 throughout; after release, the first accept goes to requester 0.
// - Single op: req0 ADD a=16'hFFFF b=16'h0002, rsp_ready=1 -> rsp_valid[0]=1 next cycle with rsp_q=16'h0001, then IDLE.
// - Round-robin: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and 1 op/cycle after the first-cycle latency.
// - Backpressure: rsp_ready[0]=0 for 3 cycles after SUB 5-7 -> rsp_q=16'hFFFE stable, req_ready=0 for both requesters, and requester 1 is granted in the cycle rsp_ready[0] rises.
// - Shift boundary: SHL a=16'h0001 b=16'd16 -> rsp_q=0; SHR a=16'h8000 b=16'd15 -> rsp_q=16'h0001.
// - Reset mid-HOLD: assert rst_n=0 while rsp_valid[1]=1 -> rsp_valid=0 the next cycle and no stale response after release; with PERF_EN, grant_cnt clears to 0.

Source files
------------

// File: rtl/core_alu_arbiter.sv
// core_alu_arbiter: round-robin sharing of one combinational core_alu among N requesters.
// Optional per-requester saturating grant counters are enabled by defining CORE_ALU_ARB_PERF_EN.
package core_alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASS
    } alu_op_t;
endpackage

module core_alu
    import core_alu_pkg::*;
#(
    parameter int W = 16
) (
    input  alu_op_t      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    localparam logic [W:0] WL = (W+1)'(W);
    logic big_sh;
    assign big_sh = {1'b0, b} >= WL;
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SHL:  y = big_sh ? '0 : a << b;
            ALU_SHR:  y = big_sh ? '0 : a >> b;
            ALU_PASS: y = b;
            default:  y = '0;
        endcase
    end
endmodule

module core_alu_arbiter
    import core_alu_pkg::*;
#(
    parameter int W    = 16,
    parameter int N    = 2,
    parameter int CNTW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_valid,
    output logic [N-1:0] req_ready,
    input  alu_op_t      req_op [N],
    input  logic [W-1:0] req_a [N],
    input  logic [W-1:0] req_b [N],
    output logic [N-1:0] rsp_valid,
    input  logic [N-1:0] rsp_ready,
    output logic [W-1:0] rsp_q
`ifdef CORE_ALU_ARB_PERF_EN
    ,
    output logic [CNTW-1:0] grant_cnt [N]
`endif
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, win;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_d, alu_y;
    logic          found, slot_free, accept;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                win   = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    core_alu #(.W(W)) u_alu (
        .op (req_op[win]),
        .a  (req_a[win]),
        .b  (req_b[win]),
        .y  (alu_y)
    );

    // rst_n gates the handshake so nothing is accepted during the reset cycle
    assign slot_free = (state_q == IDLE) | (state_q == HOLD & rsp_ready[own_q]);
    assign accept    = found & slot_free & rst_n;
    assign req_ready = accept ? N'(1) << win : '0;
    assign rsp_valid = rsp_valid_q;

    always_comb begin
        state_d     = accept ? HOLD : (slot_free ? IDLE : state_q);
        own_d       = accept ? win : own_q;
        ptr_d       = accept ? ((win == IW'(N - 1)) ? '0 : win + 1'b1) : ptr_q;
        rsp_d       = accept ? alu_y : rsp_q;
        rsp_valid_d = accept ? N'(1) << win : (slot_free ? '0 : rsp_valid_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            own_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef CORE_ALU_ARB_PERF_EN
    logic [CNTW-1:0] cnt_q [N];
    logic [CNTW-1:0] cnt_d [N];

    always_comb begin
        for (int i = 0; i < N; i++)
            cnt_d[i] = (accept && win == IW'(i) && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_core_alu_arbiter.sv
// tb_core_alu_arbiter: directed scoreboard bench for core_alu_arbiter with N=2, W=16.
// Grant counters are also checked when CORE_ALU_ARB_PERF_EN is defined.
module tb_core_alu_arbiter;
    import core_alu_pkg::*;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    alu_op_t     req_op [2];
    logic [15:0] req_a [2];
    logic [15:0] req_b [2];
    logic [15:0] rsp_q;
`ifdef CORE_ALU_ARB_PERF_EN
    logic [15:0] grant_cnt [2];
`endif

    exp_t sb[$];
    int   ptr_m = 0;
    int   gcnt [2] = '{0, 0};
    int   n_cmp = 0;
    int   n_err = 0;

    core_alu_arbiter #(.W(16), .N(2), .CNTW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q)
`ifdef CORE_ALU_ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_m(alu_op_t op, logic [15:0] a, logic [15:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SHL: return (b > 16'd15) ? 16'h0 : a << b;
            ALU_SHR: return (b > 16'd15) ? 16'h0 : a >> b;
            default: return b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        int          w;
        logic        pop, acc;
        logic [15:0] v;
        #1;
        if (sb.size() != 0) begin
            chk("sb_rsp_valid", rsp_valid, 32'(2'b01 << sb[0].idx));
            chk("sb_rsp_q", rsp_q, sb[0].val);
            pop = rsp_ready[sb[0].idx];
        end else begin
            chk("sb_rsp_valid", rsp_valid, 0);
            pop = 1'b0;
        end
        w = -1;
        for (int k = 0; k < 2; k++)
            if (w < 0 && req_valid[(ptr_m + k) % 2]) w = (ptr_m + k) % 2;
        acc = rst_n && (sb.size() == 0 || pop) && w >= 0;
        chk("sb_req_ready", req_ready, acc ? 32'(1 << w) : 0);
        v = acc ? alu_m(req_op[w], req_a[w], req_b[w]) : 16'h0;
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            ptr_m = 0;
            gcnt = '{0, 0};
        end else begin
            if (pop) void'(sb.pop_front());
            if (acc) begin
                sb.push_back('{w, v});
                ptr_m = (w + 1) % 2;
                gcnt[w]++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_op = '{ALU_ADD, ALU_ADD};
        req_a = '{16'd1, 16'd3};
        req_b = '{16'd2, 16'd4};
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
        end
        rst_n = 1'b1;
        #1 chk("first_grant", req_ready, 2'b01);
        cycle();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        cycle();
        cycle();

        req_op[0] = ALU_ADD; req_a[0] = 16'hFFFF; req_b[0] = 16'h0002;
        req_valid = 2'b01;
        cycle();
        chk("single_valid", rsp_valid, 2'b01);
        chk("single_q", rsp_q, 16'h0001);
        req_valid = 2'b00;
        cycle();
        chk("single_idle", rsp_valid, 0);

        req_op = '{ALU_XOR, ALU_SUB};
        req_a = '{16'h00FF, 16'h0010};
        req_b = '{16'h0F0F, 16'h0001};
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant", req_ready, (i % 2 == 1) ? 2'b01 : 2'b10);
            cycle();
        end
        req_valid = 2'b00;
        cycle();
        cycle();

        req_op[0] = ALU_SUB; req_a[0] = 16'd5; req_b[0] = 16'd7;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        cycle();
        req_op[1] = ALU_AND; req_a[1] = 16'h1234; req_b[1] = 16'hFF00;
        req_valid = 2'b10;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_q", rsp_q, 16'hFFFE);
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            cycle();
        end
        rsp_ready = 2'b01;
        #1 chk("bp_grant1", req_ready, 2'b10);
        cycle();
        chk("bp_rsp1", rsp_q, 16'h1200);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        cycle();
        cycle();

        req_op[0] = ALU_SHL; req_a[0] = 16'h0001; req_b[0] = 16'd16;
        req_valid = 2'b01;
        cycle();
        chk("shl_16", rsp_q, 16'h0000);
        req_op[0] = ALU_SHR; req_a[0] = 16'h8000; req_b[0] = 16'd15;
        cycle();
        chk("shr_15", rsp_q, 16'h0001);
        req_b[0] = 16'd16;
        cycle();
        chk("shr_16", rsp_q, 16'h0000);
        req_valid = 2'b00;
        cycle();

        req_op[1] = ALU_OR; req_a[1] = 16'hA0A0; req_b[1] = 16'h0505;
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        cycle();
        chk("mh_valid", rsp_valid, 2'b10);
        chk("mh_q", rsp_q, 16'hA5A5);
        rst_n = 1'b0;
        req_valid = 2'b00;
        cycle();
        chk("mh_cleared", rsp_valid, 0);
`ifdef CORE_ALU_ARB_PERF_EN
        chk("mh_cnt0", grant_cnt[0], 0);
        chk("mh_cnt1", grant_cnt[1], 0);
`endif
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        cycle();
        cycle();
        chk("mh_no_stale", rsp_valid, 0);
        req_valid = 2'b11;
        #1 chk("post_rst_grant", req_ready, 2'b01);
        cycle();
        req_valid = 2'b00;
        cycle();
        cycle();
`ifdef CORE_ALU_ARB_PERF_EN
        chk("cnt0", grant_cnt[0], gcnt[0]);
        chk("cnt1", grant_cnt[1], gcnt[1]);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
